// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: mode encoding and FSM states.
package univ_shift_reg_pkg;

  localparam logic [2:0] MODE_HOLD  = 3'd0;
  localparam logic [2:0] MODE_SHL   = 3'd1;
  localparam logic [2:0] MODE_SHR   = 3'd2;
  localparam logic [2:0] MODE_ROTL  = 3'd3;
  localparam logic [2:0] MODE_ROTR  = 3'd4;
  localparam logic [2:0] MODE_LOAD  = 3'd5;
  localparam logic [2:0] MODE_CLEAR = 3'd6;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIN} state_t;

  // Only the four shift/rotate modes are eligible for bursts.
  function automatic logic is_shift_mode(input logic [2:0] m);
    return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) || (m == MODE_ROTR);
  endfunction

endpackage

// File: rtl/univ_shift_reg_step.sv
// Combinational one-step shifter shared by single-step and burst paths.
module usr_step
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       mode,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_q,
  output logic             out_bit,
  output logic             shifted
);

  always_comb begin
    next_q  = q;
    out_bit = 1'b0;
    shifted = 1'b0;
    case (mode)
      MODE_SHL: begin
        next_q  = {q[WIDTH-2:0], sin};
        out_bit = q[WIDTH-1];
        shifted = 1'b1;
      end
      MODE_SHR: begin
        next_q  = {sin, q[WIDTH-1:1]};
        out_bit = q[0];
        shifted = 1'b1;
      end
      MODE_ROTL: begin
        next_q  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
        shifted = 1'b1;
      end
      MODE_ROTR: begin
        next_q  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
        shifted = 1'b1;
      end
      MODE_LOAD:  next_q = d;
      MODE_CLEAR: next_q = '0;
      default:    next_q = q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step operations and counted shift bursts.
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNTW  = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNTW-1:0]  nshift,
  input  logic             sin,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t            state, state_nxt;
  logic [CNTW-1:0]   cnt, cnt_nxt;
  logic [2:0]        mode_r, mode_nxt;
  logic [2:0]        step_mode;
  logic              step_en;
  logic [WIDTH-1:0]  next_q;
  logic              out_bit, shifted;

  usr_step #(.WIDTH(WIDTH)) u_step (
    .q       (q),
    .mode    (step_mode),
    .sin     (sin),
    .d       (d),
    .next_q  (next_q),
    .out_bit (out_bit),
    .shifted (shifted)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_r;
    step_en   = 1'b0;
    step_mode = mode;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        // start wins over en; an ineligible start mode is simply dropped
        if (start) begin
          if (is_shift_mode(mode)) begin
            mode_nxt  = mode;
            cnt_nxt   = nshift;
            state_nxt = (nshift == '0) ? ST_FIN : ST_RUN;
          end
        end else if (en) begin
          step_en = 1'b1;
        end
      end
      ST_RUN: begin
        busy      = 1'b1;
        step_en   = 1'b1;
        step_mode = mode_r;
        cnt_nxt   = cnt - CNTW'(1);
        if (cnt == CNTW'(1)) state_nxt = ST_FIN;
      end
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_r <= MODE_HOLD;
      q      <= '0;
      sout   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_r <= mode_nxt;
      if (step_en) q <= next_q;
      if (step_en && shifted) sout <= out_bit;
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences, random vs reference model.
module tb_univ_shift_reg;
  localparam int WIDTH = 8;
  localparam int CNTW  = 4;
  localparam int MASK  = (1 << WIDTH) - 1;

  logic             clk = 1'b0;
  logic             rst, en, start, sin;
  logic [2:0]       mode;
  logic [CNTW-1:0]  nshift;
  logic [WIDTH-1:0] d, q;
  logic             sout, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .mode(mode), .nshift(nshift),
    .sin(sin), .d(d), .q(q), .sout(sout), .busy(busy), .done(done)
  );

  typedef struct {
    logic       en, start;
    logic [2:0] mode;
    logic [3:0] nshift;
    logic       sin;
    logic [7:0] d;
    logic [7:0] eq;
    logic       es, eb, ed;
  } vec_t;

  localparam int NV = 18;
  vec_t tbl [NV];

  // reference model state
  int mq, ms, left, mmode;
  bit running, fin;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic drive(input logic e, input logic s, input logic [2:0] m,
                       input logic [CNTW-1:0] n, input logic si, input logic [WIDTH-1:0] dd);
    en = e; start = s; mode = m; nshift = n; sin = si; d = dd;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_apply(input int m, input int si, input int dd);
    case (m)
      1: begin ms = (mq >> (WIDTH-1)) & 1; mq = ((mq << 1) | si) & MASK; end
      2: begin ms = mq & 1; mq = (mq >> 1) | (si << (WIDTH-1)); end
      3: begin ms = (mq >> (WIDTH-1)) & 1; mq = ((mq << 1) | ms) & MASK; end
      4: begin ms = mq & 1; mq = (mq >> 1) | (ms << (WIDTH-1)); end
      5: mq = dd;
      6: mq = 0;
      default: ;
    endcase
  endtask

  task automatic model_edge(input int e, input int s, input int m, input int n, input int si, input int dd);
    if (running) begin
      model_apply(mmode, si, dd);
      left--;
      if (left == 0) begin running = 0; fin = 1; end
    end else if (fin) begin
      fin = 0;
    end else if (s != 0) begin
      if (m >= 1 && m <= 4) begin
        mmode = m;
        if (n == 0) fin = 1;
        else begin running = 1; left = n; end
      end
    end else if (e != 0) begin
      model_apply(m, si, dd);
    end
  endtask

  task automatic model_reset;
    mq = 0; ms = 0; left = 0; mmode = 0; running = 0; fin = 0;
  endtask

  initial begin
    int n;
    bit saw_done;
    //          en start mode n sin d     q     sout busy done
    tbl[0]  = '{1, 0, 3'd5, 0, 0, 8'h81, 8'h81, 0, 0, 0};
    tbl[1]  = '{1, 0, 3'd1, 0, 1, 8'h00, 8'h03, 1, 0, 0};
    tbl[2]  = '{1, 0, 3'd2, 0, 0, 8'h00, 8'h01, 1, 0, 0};
    tbl[3]  = '{0, 1, 3'd3, 3, 0, 8'h00, 8'h01, 1, 1, 0};
    tbl[4]  = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h02, 0, 1, 0};
    tbl[5]  = '{1, 0, 3'd5, 0, 0, 8'hFF, 8'h04, 0, 1, 0};
    tbl[6]  = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h08, 0, 0, 1};
    tbl[7]  = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h08, 0, 0, 0};
    tbl[8]  = '{0, 1, 3'd1, 0, 1, 8'h00, 8'h08, 0, 0, 1};
    tbl[9]  = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h08, 0, 0, 0};
    tbl[10] = '{0, 1, 3'd5, 3, 0, 8'hFF, 8'h08, 0, 0, 0};
    tbl[11] = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h08, 0, 0, 0};
    tbl[12] = '{1, 1, 3'd1, 1, 1, 8'h00, 8'h08, 0, 1, 0};
    tbl[13] = '{0, 0, 3'd0, 0, 1, 8'h00, 8'h11, 0, 0, 1};
    tbl[14] = '{0, 0, 3'd0, 0, 0, 8'h00, 8'h11, 0, 0, 0};
    tbl[15] = '{1, 0, 3'd4, 0, 0, 8'h00, 8'h88, 1, 0, 0};
    tbl[16] = '{1, 0, 3'd6, 0, 0, 8'h00, 8'h00, 1, 0, 0};
    tbl[17] = '{1, 0, 3'd7, 0, 0, 8'hFF, 8'h00, 1, 0, 0};

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    repeat (2) tick();
    chk("reset_q", q, 0);
    chk("reset_sout", sout, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].en, tbl[i].start, tbl[i].mode, tbl[i].nshift, tbl[i].sin, tbl[i].d);
      tick();
      chk($sformatf("vec%0d_q", i), q, tbl[i].eq);
      chk($sformatf("vec%0d_sout", i), sout, tbl[i].es);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("vec%0d_done", i), done, tbl[i].ed);
    end

    // wrap: rotl by 9 on 8 bits lands one place over
    drive(1, 0, 3'd5, 0, 0, 8'h80); tick();
    drive(0, 1, 3'd3, 9, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("wrap_latency", n, 10);
    chk("wrap_q", q, 8'h01);
    chk("wrap_sout", sout, 1);
    chk("wrap_busy", busy, 0);
    tick();

    // count above WIDTH: rotr by 15 == rotr by 7
    drive(1, 0, 3'd5, 0, 0, 8'h01); tick();
    drive(0, 1, 3'd4, 15, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    n = 1;
    while (!done && n < 40) begin tick(); n++; end
    chk("rotr15_latency", n, 16);
    chk("rotr15_q", q, 8'h02);
    tick();

    // reset mid-burst aborts without done
    drive(1, 0, 3'd5, 0, 0, 8'hA5); tick();
    drive(0, 1, 3'd3, 6, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0);
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    chk("rstmid_q", q, 8'h00);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    tick();
    #2 rst = 1'b0;
    saw_done = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (done) saw_done = 1; end
    chk("rstmid_nodone", saw_done, 0);
    drive(1, 0, 3'd5, 0, 0, 8'h3C); tick();
    chk("rstmid_first_op", q, 8'h3C);

    // random against reference model
    #2 rst = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 1500; i++) begin
      int e, s, m, nn, si, dd;
      e  = $urandom_range(0, 1);
      s  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      m  = $urandom_range(0, 7);
      nn = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 4);
      si = $urandom_range(0, 1);
      dd = $urandom_range(0, MASK);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        #2 rst = 1'b0;
        model_reset();
        chk("rnd_rst_q", q, 0);
        chk("rnd_rst_busy", busy, 0);
      end
      drive(e[0], s[0], m[2:0], nn[CNTW-1:0], si[0], dd[WIDTH-1:0]);
      model_edge(e, s, m, nn, si, dd);
      tick();
      chk("rnd_q", q, mq);
      chk("rnd_sout", sout, ms);
      chk("rnd_busy", busy, running);
      chk("rnd_done", done, fin);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8, data register width; legal range 2..64.
REQ-002 Parameter CNTW, default $clog2(WIDTH)+1, width of the burst shift-count field.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  single-step operation strobe, sampled each rising edge.
REQ-006 start  input  1  burst request strobe, sampled each rising edge.
REQ-007 mode  input  3  operation: 0 hold, 1 shl, 2 shr, 3 rotl, 4 rotr, 5 load, 6 clear, 7 hold.
REQ-008 nshift  input  CNTW  burst shift count, sampled with start.
REQ-009 sin  input  1  serial input bit, inserted at LSB for shl and at MSB for shr.
REQ-010 d  input  WIDTH  parallel load data.
REQ-011 q  output  WIDTH  register contents.
REQ-012 sout  output  1  registered copy of the last bit shifted or rotated out.
REQ-013 busy  output  1  high while a burst is in progress.
REQ-014 done  output  1  one-cycle pulse at the end of each burst.

Function
REQ-015 FSM states: IDLE, RUN, FIN; reset state IDLE.
REQ-016 IDLE, en=1, start=0: apply mode once; q updates at the next edge (1-cycle latency).
REQ-017 shl: q <= {q[WIDTH-2:0], sin}; sout <= q[WIDTH-1].
REQ-018 shr: q <= {sin, q[WIDTH-1:1]}; sout <= q[0].
REQ-019 rotl/rotr: circular shift by one; sout <= the bit that wraps around.
REQ-020 load: q <= d; clear: q <= 0; hold/7: q unchanged; sout unchanged for these modes.
REQ-021 IDLE, start=1, mode in 1..4, nshift>0: latch mode and nshift, enter RUN, busy=1 from the next cycle.
REQ-022 RUN: one shift per cycle using the latched mode and the live sin; remaining count decrements; after the nshift-th shift, go to FIN.
REQ-023 FIN: done=1 and busy=0 for exactly one cycle, then IDLE; total burst = nshift+1 cycles from the start edge to the done cycle.
REQ-024 start with nshift=0: no shift; go directly to FIN, so done pulses on the following cycle.
REQ-025 start with mode in 0,5,6,7: ignored; no state change and no done pulse.
REQ-026 start=1 and en=1 together in IDLE: start takes priority; en is ignored.
REQ-027 en and start are ignored while in RUN or FIN; mode and nshift changes during RUN have no effect.
REQ-028 nshift values greater than WIDTH are honoured literally; rotation wraps modulo WIDTH.

Reset
REQ-029 rst=1 forces, asynchronously: q=0, sout=0, busy=0, done=0, FSM=IDLE, count=0.
REQ-030 Reset asserted during RUN aborts the burst with no done pulse; the first operation is accepted on the first rising edge after rst deasserts.

Structure
REQ-031 A shared package holds the mode encoding constants (MODE_HOLD..MODE_CLEAR) and the FSM state typedef.
REQ-032 One sub-module, usr_step, is a combinational one-step shifter (q, mode, sin -> next_q, out_bit) shared by single-step and burst paths.
REQ-033 The top level contains only the FSM, the counter, and the q/sout registers.

Verification (WIDTH=8)
REQ-034 Reset mid-burst: after load 0xA5, start rotl nshift=6, assert rst in cycle 3 -> q=0x00, busy=0, no done pulse.
REQ-035 Single-step: load d=0x81, then en shl sin=1 -> q=0x03, sout=1; then en shr sin=0 -> q=0x01, sout=1.
REQ-036 Burst: q=0x01, start rotl nshift=3 -> busy high 3 cycles, q=0x08, done pulse on cycle 4, busy low during done.
REQ-037 Wrap: q=0x80, start rotl nshift=9 -> q=0x01 at done, sout=1.
REQ-038 Edge cases, each checked from IDLE with no prior burst pending:
- start nshift=0 -> q unchanged, done pulses on the next cycle.
- start with mode=load -> ignored; no done pulse.
- start and en together -> burst runs; en is ignored.
- en asserted during RUN -> no effect on q.
